// File: rtl/pop_counter_bank.sv
// Bank of per-channel FIFO pop counters with an indexed, IDLE-gated read port.
// Define CNT_CLR_ON_READ_EN to make in-range reads clear the selected counter and its ovf bit.
module pop_counter_bank #(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 5,
  parameter int IDX_W    = 3,
  parameter int SAT_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              IDLE,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NUM_CH-1:0] fifo_pop,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              err,
  output logic [NUM_CH-1:0] ovf
);

  typedef enum logic {
    R_WAIT,
    R_RESP
  } r_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W:0] CH_LIM = (IDX_W+1)'(NUM_CH);

  r_state_t         state_q;
  r_state_t         state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] clr;
  logic [CNT_W-1:0] sel_cnt;
  logic             accept;
  logic             in_range;

  assign accept   = req & IDLE;
  assign in_range = {1'b0, idx} < CH_LIM;
  assign valid    = (state_q == R_RESP);

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) sel_cnt = cnt_q[i];
    end
  end

`ifdef CNT_CLR_ON_READ_EN
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i] = accept & in_range & (idx == IDX_W'(i));
    end
  end
`else
  assign clr = '0;
`endif

  // A read-clear wins over the pop, but the pop still lands.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf[i];
      if (clr[i]) begin
        cnt_d[i] = CNT_W'(fifo_pop[i]);
        ovf_d[i] = 1'b0;
      end else if (fifo_pop[i] && cnt_q[i] == CNT_MAX) begin
        ovf_d[i] = 1'b1;
        cnt_d[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
      end else if (fifo_pop[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_WAIT:  if (accept) state_d = R_RESP;
      R_RESP:  state_d = accept ? R_RESP : R_WAIT;
      default: state_d = R_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= R_WAIT;
      cnt_q    <= '{default: '0};
      ovf      <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf     <= ovf_d;
      if (accept) begin
        data_out <= in_range ? sel_cnt : '0;
        err      <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_pop_counter_bank.sv
// Scoreboard bench for pop_counter_bank: a wrapping and a saturating
// instance share stimulus and are checked against a bench model.
module tb_pop_counter_bank;

  localparam int NCH = 5;
  localparam int CW  = 5;
  localparam int IW  = 3;
`ifdef CNT_CLR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [CW-1:0] w;
    logic [CW-1:0] s;
    logic          e;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          IDLE = 1'b0;
  logic          req = 1'b0;
  logic [IW-1:0] idx = '0;
  logic [NCH-1:0] fifo_pop = '0;

  logic          valid_w, valid_s;
  logic [CW-1:0] data_w, data_s;
  logic          err_w, err_s;
  logic [NCH-1:0] ovf_w, ovf_s;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  exp_t q[$];

  logic [CW-1:0] m_cnt [NCH];
  logic [CW-1:0] s_cnt [NCH];
  logic [NCH-1:0] m_ovf, s_ovf;

  always #5 clk = ~clk;

  pop_counter_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .IDX_W(IW), .SAT_MODE(0)
  ) u_w (
    .clk(clk), .reset_L(reset_L), .IDLE(IDLE), .req(req),
    .idx(idx), .fifo_pop(fifo_pop), .valid(valid_w),
    .data_out(data_w), .err(err_w), .ovf(ovf_w)
  );

  pop_counter_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .IDX_W(IW), .SAT_MODE(1)
  ) u_s (
    .clk(clk), .reset_L(reset_L), .IDLE(IDLE), .req(req),
    .idx(idx), .fifo_pop(fifo_pop), .valid(valid_s),
    .data_out(data_s), .err(err_s), .ovf(ovf_s)
  );

  // Response monitor: each expected entry must appear at its due negedge.
  always @(negedge clk) begin
    exp_t e;
    if (valid_w || valid_s) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid vw=%0b vs=%0b cyc=%0d",
                 valid_w, valid_s, ncyc);
      end else begin
        e = q.pop_front();
        if (valid_w !== 1'b1 || valid_s !== 1'b1 || data_w !== e.w ||
            data_s !== e.s || err_w !== e.e || err_s !== e.e ||
            e.due != ncyc) begin
          bad++;
          $display("FAIL resp got v=%0b/%0b d=%0d/%0d e=%0b/%0b cyc=%0d exp d=%0d/%0d e=%0b cyc=%0d",
                   valid_w, valid_s, data_w, data_s, err_w, err_s, ncyc,
                   e.w, e.s, e.e, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= ncyc) begin
      total++;
      bad++;
      e = q.pop_front();
      $display("FAIL missing_valid got valid=0 exp valid=1 d=%0d cyc=%0d",
               e.w, e.due);
    end
    ncyc++;
  end

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = '0;
      s_cnt[i] = '0;
    end
    m_ovf = '0;
    s_ovf = '0;
    q.delete();
  endtask

  task automatic cycle(input logic [NCH-1:0] pop, input logic rq,
                       input logic idl, input logic [IW-1:0] ix);
    exp_t e;
    bit acc;
    bit oor;
    fifo_pop = pop;
    req = rq;
    IDLE = idl;
    idx = ix;
    @(posedge clk);
    acc = rq && idl;
    oor = (int'(ix) >= NCH);
    if (acc) begin
      e.e = oor;
      e.w = oor ? '0 : m_cnt[ix];
      e.s = oor ? '0 : s_cnt[ix];
      e.due = ncyc;
      q.push_back(e);
    end
    for (int i = 0; i < NCH; i++) begin
      if (pop[i]) begin
        if (m_cnt[i] == 5'd31) begin
          m_cnt[i] = '0;
          m_ovf[i] = 1'b1;
        end else m_cnt[i] = m_cnt[i] + 5'd1;
        if (s_cnt[i] == 5'd31) s_ovf[i] = 1'b1;
        else s_cnt[i] = s_cnt[i] + 5'd1;
      end
    end
    if (CLR && acc && !oor) begin
      m_cnt[ix] = pop[ix] ? 5'd1 : 5'd0;
      s_cnt[ix] = pop[ix] ? 5'd1 : 5'd0;
      m_ovf[ix] = 1'b0;
      s_ovf[ix] = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    fifo_pop = '0;
    req = 1'b0;
    IDLE = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    model_clear();
    #1;
    total++;
    if (valid_w !== 1'b0 || data_w !== '0 || err_w !== 1'b0 || ovf_w !== '0 ||
        valid_s !== 1'b0 || data_s !== '0 || ovf_s !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%0b d=%0d e=%0b ovf=%b exp 0",
               valid_w, data_w, err_w, ovf_w);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_count_read();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(5'b00100, 1'b0, 1'b1, 3'd0);
    cycle(5'b00000, 1'b1, 1'b1, 3'd2);
    total++;
    if (valid_w !== 1'b1 || data_w !== 5'd3 || err_w !== 1'b0) begin
      bad++;
      $display("FAIL t2_read got v=%0b d=%0d e=%0b exp v=1 d=3 e=0",
               valid_w, data_w, err_w);
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
    total++;
    if (valid_w !== 1'b0) begin
      bad++;
      $display("FAIL t2_one_pulse got valid=%0b exp 0", valid_w);
    end
  endtask

  task automatic test_gating_err();
    apply_reset();
    cycle(5'b10000, 1'b0, 1'b1, 3'd0);
    cycle(5'b10000, 1'b0, 1'b1, 3'd0);
    cycle(5'b00000, 1'b1, 1'b1, 3'd4);
    total++;
    if (valid_w !== 1'b1 || data_w !== 5'd2 || err_w !== 1'b0) begin
      bad++;
      $display("FAIL t3_idx4 got v=%0b d=%0d e=%0b exp v=1 d=2 e=0",
               valid_w, data_w, err_w);
    end
    cycle(5'b00000, 1'b1, 1'b0, 3'd4);
    total++;
    if (valid_w !== 1'b0 || data_w !== 5'd2) begin
      bad++;
      $display("FAIL t3_idle_gate got v=%0b d=%0d exp v=0 d=2(held)",
               valid_w, data_w);
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
    total++;
    if (valid_w !== 1'b0) begin
      bad++;
      $display("FAIL t3_idle_gate2 got valid=%0b exp 0", valid_w);
    end
    cycle(5'b00000, 1'b1, 1'b1, 3'd6);
    total++;
    if (valid_w !== 1'b1 || data_w !== 5'd0 || err_w !== 1'b1 ||
        err_s !== 1'b1) begin
      bad++;
      $display("FAIL t3_idx6 got v=%0b d=%0d e=%0b exp v=1 d=0 e=1",
               valid_w, data_w, err_w);
    end
    cycle(5'b00000, 1'b1, 1'b1, 3'd5);
    total++;
    if (err_w !== 1'b1 || data_w !== 5'd0) begin
      bad++;
      $display("FAIL t3_idx5 got d=%0d e=%0b exp d=0 e=1", data_w, err_w);
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 31; i++) cycle(5'b00001, 1'b0, 1'b1, 3'd0);
    total++;
    if (ovf_w !== 5'b0 || ovf_s !== 5'b0) begin
      bad++;
      $display("FAIL t4_no_ovf_yet got w=%b s=%b exp 0", ovf_w, ovf_s);
    end
    cycle(5'b00001, 1'b0, 1'b1, 3'd0);
    cycle(5'b00001, 1'b0, 1'b1, 3'd0);
    cycle(5'b00000, 1'b1, 1'b1, 3'd0);
    total++;
    if (data_w !== 5'd1 || data_s !== 5'd31) begin
      bad++;
      $display("FAIL t4_value got wrap=%0d sat=%0d exp wrap=1 sat=31",
               data_w, data_s);
    end
    total++;
    if (ovf_w !== (CLR ? 5'b0 : 5'b1) || ovf_s !== (CLR ? 5'b0 : 5'b1)) begin
      bad++;
      $display("FAIL t4_ovf got w=%b s=%b exp %b", ovf_w, ovf_s,
               CLR ? 5'b0 : 5'b1);
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 33; i++) cycle(5'b00001, 1'b0, 1'b1, 3'd0);
    cycle(5'b00000, 1'b1, 1'b1, 3'd0);
    total++;
    if (valid_w !== 1'b1 || ovf_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL t1_pre got v=%0b ovf=%b exp v=1 ovf0=1", valid_w, ovf_w);
    end
    #1;
    reset_L = 1'b0;
    model_clear();
    #1;
    total++;
    if (valid_w !== 1'b0 || data_w !== '0 || ovf_w !== '0 ||
        valid_s !== 1'b0 || data_s !== '0 || ovf_s !== '0) begin
      bad++;
      $display("FAIL t1_async got v=%0b d=%0d ovf=%b exp all 0",
               valid_w, data_w, ovf_w);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(5'b00010, 1'b0, 1'b1, 3'd0);
    cycle(5'b00010, 1'b1, 1'b1, 3'd1);
    total++;
    if (data_w !== 5'd4 || valid_w !== 1'b1) begin
      bad++;
      $display("FAIL t5_old got v=%0b d=%0d exp v=1 d=4", valid_w, data_w);
    end
    cycle(5'b00000, 1'b1, 1'b1, 3'd1);
    total++;
    if (data_w !== (CLR ? 5'd1 : 5'd5)) begin
      bad++;
      $display("FAIL t5_next got d=%0d exp %0d", data_w, CLR ? 1 : 5);
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(5'b11111, 1'b0, 1'b1, 3'd0);
    cycle(5'b11111, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < NCH; i++) begin
      cycle(5'b00000, 1'b1, 1'b1, IW'(i));
      total++;
      if (valid_w !== 1'b1 || data_w !== 5'd2 || err_w !== 1'b0) begin
        bad++;
        $display("FAIL t6_b2b ch=%0d got v=%0b d=%0d exp v=1 d=2",
                 i, valid_w, data_w);
      end
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL t6_drain got pending=%0d exp 0", q.size());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(NCH'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), IW'($urandom_range(0, 7)));
    end
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
    total++;
    if (ovf_w !== m_ovf || ovf_s !== s_ovf) begin
      bad++;
      $display("FAIL rnd_ovf got w=%b s=%b exp w=%b s=%b",
               ovf_w, ovf_s, m_ovf, s_ovf);
    end
    for (int i = 0; i < NCH; i++) cycle(5'b00000, 1'b1, 1'b1, IW'(i));
    cycle(5'b00000, 1'b0, 1'b1, 3'd0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain got pending=%0d exp 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_count_read();
    test_gating_err();
    test_overflow();
    test_async_reset();
    test_simultaneous();
    test_back_to_back();
    test_random();
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
